ascii_time_sender: RTL and testbench
====================================

Name: ascii_time_sender

Overview:
Sequences the UART transmitter to send one snapshot of the 8 display BCD digits as ASCII text, "HH:MM:SS.CC" followed by optional CR LF.
It sits between the FND controller's 32-bit sender_data output and the uart_tx block.
It captures the digits on a send request, then issues one byte per tx_start/tx_done handshake until the frame is complete.

Parameters:
SEND_CRLF, 1, 1 = append 0x0D 0x0A (13-byte frame); 0 = 11-byte frame with no terminator.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
send_start  input  1  request pulse; only sampled in IDLE.
sender_data  input  32  8 BCD nibbles, [31:28] hour10 … [3:0] msec1.
tx_busy  input  1  uart_tx is busy; no tx_start may be issued while it is high.
tx_done  input  1  1-cycle pulse from uart_tx when the current byte's stop bit completes.
tx_start  output  1  1-cycle request to uart_tx to send tx_data.
tx_data  output  8  byte to transmit; registered and stable from the tx_start cycle until the next tx_start.
sending  output  1  high from frame acceptance until the frame's last tx_done.
frame_done  output  1  1-cycle pulse after the last byte's tx_done.

Behaviour:
- Reset values: tx_start=0, tx_data=8'h00, sending=0, frame_done=0, state=IDLE, byte index=0, snapshot=0.
- States: IDLE, ISSUE, WAIT, NEXT, DONE.
- IDLE
  - On send_start=1: snapshot<=sender_data, index<=0, sending<=1, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE
  - If tx_busy=0: tx_start<=1 for exactly one cycle, tx_data<=char(index), go to WAIT.
  - If tx_busy=1: hold in ISSUE with tx_start=0.
- WAIT
  - Hold until tx_done=1, then go to NEXT.
  - tx_done seen in IDLE, ISSUE, NEXT or DONE is ignored. tx_done is only counted in WAIT.
- NEXT
  - If index==LAST: go to DONE. LAST = 12 when SEND_CRLF=1, 10 when SEND_CRLF=0.
  - Else index<=index+1, go to ISSUE.
- DONE: frame_done<=1 for one cycle, sending<=0, return to IDLE.
- Latency: send_start sampled at edge N, tx_busy=0 → tx_start high in the cycle after edge N+1. Between tx_done and the next tx_start there are 2 clock cycles (NEXT, ISSUE).
- Byte map, by index:
  - 0 = h10, 1 = h1, 2 = ':' (0x3A)
  - 3 = m10, 4 = m1, 5 = ':'
  - 6 = s10, 7 = s1, 8 = '.' (0x2E)
  - 9 = c10, 10 = c1
  - 11 = 0x0D, 12 = 0x0A
- Digit to ASCII: nibble 0–9 → 8'h30+nibble. Nibble 10–15 → '?' (0x3F).
- Digits are always taken from the snapshot. sender_data changes after acceptance do not affect the frame in flight.
- send_start while not in IDLE is dropped, not queued.
- send_start in the same cycle as frame_done is dropped, because the state is DONE, not IDLE.
- Asynchronous reset mid-frame:
  - Immediately forces all outputs to reset values and the state to IDLE.
  - No further tx_start is issued.
  - A byte already handed to uart_tx is that block's concern.
- The index is 4 bits and never exceeds LAST. There is no wrap-around path.

Test Plan:
1. Basic frame: SEND_CRLF=1, sender_data=32'h1234_5678, send_start pulse, uart_tx model with tx_done 10 cycles after each tx_start → exactly 13 tx_start pulses; bytes 31 32 3A 33 34 3A 35 36 2E 37 38 0D 0A; one frame_done; sending falls in the same cycle as frame_done.
2. Snapshot and drop: start with 32'h2359_5999, change sender_data to 32'h0000_0000 and pulse send_start after byte 3 → output reads "23:59:59.99\r\n"; only 13 bytes sent in total, i.e. the second request is dropped.
3. Busy stall: tx_busy held high for 20 cycles at frame start → tx_start stays 0 throughout; the first tx_start appears in the cycle after tx_busy falls.
4. Invalid digit: sender_data=32'hA000_00F0 → bytes 0 and 9 are 0x3F; all other digits are 0x30.
5. Reset mid-frame: assert reset after the 5th tx_start → tx_start=0, sending=0, tx_data=00 immediately; a new send_start after release sends a full fresh frame from index 0.
6. SEND_CRLF=0 with sender_data=32'h0102_0304 → 11 bytes "01:02:03.04"; frame_done follows the 11th tx_done.

Source files
------------

// File: rtl/ascii_time_sender_if.sv
// Handshake bundle between the time sender, its request source and uart_tx.
// The master side drives requests and uart status; the slave is the sender.
interface ascii_time_sender_if;
   logic        send_start;
   logic [31:0] sender_data;
   logic        tx_busy;
   logic        tx_done;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        sending;
   logic        frame_done;

   modport master (
      output send_start, sender_data, tx_busy, tx_done,
      input  tx_start, tx_data, sending, frame_done
   );

   modport slave (
      input  send_start, sender_data, tx_busy, tx_done,
      output tx_start, tx_data, sending, frame_done
   );
endinterface

// File: rtl/ascii_time_sender.sv
// Sends a snapshot of eight BCD display digits as "HH:MM:SS.CC" (+ optional CR LF)
// through uart_tx, one byte per tx_start/tx_done handshake.
module ascii_time_sender #(
   parameter bit SEND_CRLF = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   ascii_time_sender_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_NEXT,
      S_DONE
   } state_t;

   localparam logic [3:0] LAST_IDX = SEND_CRLF ? 4'd12 : 4'd10;

   state_t      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [31:0] snap_q, snap_d;
   logic        tx_start_q, tx_start_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        sending_q, sending_d;
   logic        frame_done_q, frame_done_d;

   logic [7:0]  digit_ascii [8];
   logic [7:0]  char_sel;

   // digit_ascii[7] is hour10, digit_ascii[0] is the last hundredths digit
   for (genvar gi = 0; gi < 8; gi++) begin : g_digit
      logic [3:0] nib;
      assign nib = snap_q[4*gi +: 4];
      assign digit_ascii[gi] = (nib <= 4'd9) ? (8'h30 + {4'h0, nib}) : 8'h3F;
   end

   always_comb begin
      char_sel = 8'h00;
      case (idx_q)
         4'd0:    char_sel = digit_ascii[7];
         4'd1:    char_sel = digit_ascii[6];
         4'd2:    char_sel = 8'h3A;
         4'd3:    char_sel = digit_ascii[5];
         4'd4:    char_sel = digit_ascii[4];
         4'd5:    char_sel = 8'h3A;
         4'd6:    char_sel = digit_ascii[3];
         4'd7:    char_sel = digit_ascii[2];
         4'd8:    char_sel = 8'h2E;
         4'd9:    char_sel = digit_ascii[1];
         4'd10:   char_sel = digit_ascii[0];
         4'd11:   char_sel = 8'h0D;
         4'd12:   char_sel = 8'h0A;
         default: char_sel = 8'h00;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      snap_d       = snap_q;
      tx_start_d   = 1'b0;
      tx_data_d    = tx_data_q;
      sending_d    = sending_q;
      frame_done_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.send_start) begin
               snap_d    = bus.sender_data;
               idx_d     = 4'd0;
               sending_d = 1'b1;
               state_d   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!bus.tx_busy) begin
               tx_start_d = 1'b1;
               tx_data_d  = char_sel;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.tx_done) begin
               state_d = S_NEXT;
            end
         end
         S_NEXT: begin
            if (idx_q == LAST_IDX) begin
               // Flags are raised on entry so frame_done is high while in DONE,
               // which is what makes a coincident send_start get dropped.
               frame_done_d = 1'b1;
               sending_d    = 1'b0;
               state_d      = S_DONE;
            end else begin
               idx_d   = idx_q + 4'd1;
               state_d = S_ISSUE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         idx_q        <= 4'd0;
         snap_q       <= 32'h0;
         tx_start_q   <= 1'b0;
         tx_data_q    <= 8'h00;
         sending_q    <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         snap_q       <= snap_d;
         tx_start_q   <= tx_start_d;
         tx_data_q    <= tx_data_d;
         sending_q    <= sending_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bus.tx_start   = tx_start_q;
   assign bus.tx_data    = tx_data_q;
   assign bus.sending    = sending_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_ascii_time_sender.sv
// Bench for ascii_time_sender: one CR LF instance and one bare instance, each
// served by a behavioural uart_tx model; frames are checked against expected text.
module tb_ascii_time_sender;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   ascii_time_sender_if ifs[2] ();

   ascii_time_sender #(.SEND_CRLF(1'b1)) dut_a (.clk(clk), .reset(rst), .bus(ifs[0]));
   ascii_time_sender #(.SEND_CRLF(1'b0)) dut_b (.clk(clk), .reset(rst), .bus(ifs[1]));

   // stimulus driven by the main sequence
   logic        ss [2];
   logic [31:0] sd [2];
   logic        force_busy;
   int          dly_fix [2];

   // uart model state and observations
   bit          busy_m [2];
   bit          done_m [2];
   int          cnt_m [2];
   bit          ld_valid [2];
   int          last_done [2];
   logic [7:0]  prev_data [2];
   byte unsigned cap [2][$];
   int          fd_cnt [2];
   int          fd_gap [2];
   logic        fd_send [2];
   int          viol [2];
   int          gap_err [2];
   int          stab_err [2];

   for (genvar gi = 0; gi < 2; gi++) begin : g_uart
      assign ifs[gi].send_start  = ss[gi];
      assign ifs[gi].sender_data = sd[gi];
      assign ifs[gi].tx_busy     = busy_m[gi] | ((gi == 0) ? force_busy : 1'b0);
      assign ifs[gi].tx_done     = done_m[gi];

      always @(negedge clk) begin
         if (rst) begin
            busy_m[gi]    = 1'b0;
            done_m[gi]    = 1'b0;
            cnt_m[gi]     = 0;
            ld_valid[gi]  = 1'b0;
            prev_data[gi] = 8'h00;
         end else begin
            done_m[gi] = 1'b0;
            if (ifs[gi].tx_start) begin
               cap[gi].push_back(ifs[gi].tx_data);
               if (ifs[gi].tx_busy) viol[gi]++;
               if (ld_valid[gi] && (cyc - last_done[gi] != 3)) gap_err[gi]++;
               ld_valid[gi] = 1'b0;
               busy_m[gi]   = 1'b1;
               cnt_m[gi]    = (dly_fix[gi] != 0) ? dly_fix[gi] : int'($urandom_range(12, 3));
            end else begin
               if (ifs[gi].tx_data !== prev_data[gi]) stab_err[gi]++;
               if (busy_m[gi]) begin
                  cnt_m[gi]--;
                  if (cnt_m[gi] == 0) begin
                     busy_m[gi]    = 1'b0;
                     done_m[gi]    = 1'b1;
                     last_done[gi] = cyc;
                     ld_valid[gi]  = 1'b1;
                  end
               end
            end
            prev_data[gi] = ifs[gi].tx_data;
            if (ifs[gi].frame_done) begin
               fd_cnt[gi]++;
               fd_gap[gi]   = ld_valid[gi] ? (cyc - last_done[gi]) : -1;
               fd_send[gi]  = ifs[gi].sending;
               ld_valid[gi] = 1'b0;
            end
         end
      end
   end

   int n_cmp  = 0;
   int n_fail = 0;
   byte unsigned exp_q[$];

   typedef struct {
      logic [31:0] data;
      string       text;
   } vec_t;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   function automatic byte unsigned asc(input logic [3:0] n);
      string digits = "0123456789";
      return (n < 4'd10) ? digits[n] : "?";
   endfunction

   task automatic build_text(input string s, input bit crlf);
      exp_q.delete();
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
      if (crlf) begin
         exp_q.push_back(8'd13);
         exp_q.push_back(8'd10);
      end
   endtask

   // Reference: four digit pairs joined by ':' ':' '.', then optional CR LF
   task automatic build_model(input logic [31:0] d, input bit crlf);
      byte unsigned seps [3] = '{8'h3A, 8'h3A, 8'h2E};
      exp_q.delete();
      for (int p = 0; p < 4; p++) begin
         logic [7:0] pair;
         pair = d[31 - 8*p -: 8];
         exp_q.push_back(asc(pair[7:4]));
         exp_q.push_back(asc(pair[3:0]));
         if (p < 3) exp_q.push_back(seps[p]);
      end
      if (crlf) begin
         exp_q.push_back(8'd13);
         exp_q.push_back(8'd10);
      end
   endtask

   task automatic pulse_start(input int id, input logic [31:0] d);
      @(negedge clk);
      sd[id] = d;
      ss[id] = 1'b1;
      @(negedge clk);
      ss[id] = 1'b0;
   endtask

   task automatic wait_bytes(input int id, input int n, input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (cap[id].size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic compare_bytes(input string name, input int id, input int base, input int fd0);
      int got_n;
      got_n = cap[id].size() - base;
      check($sformatf("%s_count", name), got_n, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         logic [31:0] g;
         g = (base + i < cap[id].size()) ? 32'(cap[id][base + i]) : 32'h100;
         check($sformatf("%s_byte%0d", name, i), g, exp_q[i]);
      end
      check($sformatf("%s_frame_done_count", name), fd_cnt[id] - fd0, 1);
      check($sformatf("%s_done_after_last_txdone", name), fd_gap[id], 2);
      check($sformatf("%s_sending_with_frame_done", name), fd_send[id], 1'b0);
      $display("frame %s dut%0d: %0d bytes captured, %0d expected", name, id, got_n, exp_q.size());
   endtask

   task automatic check_frame(input string name, input int id, input int base, input int fd0);
      bit ok = 1'b0;
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         if (fd_cnt[id] != fd0) begin
            ok = 1'b1;
            break;
         end
      end
      check($sformatf("%s_frame_done_seen", name), ok, 1'b1);
      repeat (2) @(negedge clk);
      compare_bytes(name, id, base, fd0);
   endtask

   initial begin
      vec_t tbl [4];
      int   base, fd0, seen;
      bit   ok;
      logic [31:0] rd;

      tbl[0] = '{32'hA000_00F0, "?0:00:00.?0"};
      tbl[1] = '{32'h0959_1200, "09:59:12.00"};
      tbl[2] = '{32'hFFFF_FFFF, "??:??:??.??"};
      tbl[3] = '{32'h9876_5432, "98:76:54.32"};

      rst        = 1'b1;
      ss[0]      = 1'b0;
      ss[1]      = 1'b0;
      sd[0]      = 32'h0;
      sd[1]      = 32'h0;
      force_busy = 1'b0;
      dly_fix[0] = 10;
      dly_fix[1] = 0;
      repeat (3) @(negedge clk);
      check("reset_tx_start", ifs[0].tx_start, 1'b0);
      check("reset_tx_data", ifs[0].tx_data, 8'h00);
      check("reset_sending", ifs[0].sending, 1'b0);
      check("reset_frame_done", ifs[0].frame_done, 1'b0);
      check("reset_b_sending", ifs[1].sending, 1'b0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // basic frame with latency checks
      base = cap[0].size();
      fd0  = fd_cnt[0];
      build_text("12:34:56.78", 1'b1);
      @(negedge clk);
      sd[0] = 32'h1234_5678;
      ss[0] = 1'b1;
      @(negedge clk);
      ss[0] = 1'b0;
      check("latency_no_start_yet", ifs[0].tx_start, 1'b0);
      check("latency_sending_high", ifs[0].sending, 1'b1);
      @(negedge clk);
      check("latency_first_start", ifs[0].tx_start, 1'b1);
      check_frame("basic", 0, base, fd0);
      dly_fix[0] = 0;

      for (int t = 0; t < 4; t++) begin
         base = cap[0].size();
         fd0  = fd_cnt[0];
         build_text(tbl[t].text, 1'b1);
         pulse_start(0, tbl[t].data);
         check_frame($sformatf("table%0d", t), 0, base, fd0);
      end

      // snapshot held while sender_data changes; mid-frame request dropped
      base = cap[0].size();
      fd0  = fd_cnt[0];
      build_text("23:59:59.99", 1'b1);
      pulse_start(0, 32'h2359_5999);
      wait_bytes(0, base + 3, 400, ok);
      check("snap_reach_byte3", ok, 1'b1);
      pulse_start(0, 32'h0000_0000);
      check_frame("snapshot", 0, base, fd0);
      repeat (80) @(negedge clk);
      check("snap_total_bytes", cap[0].size() - base, 13);
      check("snap_idle_sending", ifs[0].sending, 1'b0);

      // send_start coinciding with frame_done is dropped
      base = cap[0].size();
      fd0  = fd_cnt[0];
      build_text("11:22:33.44", 1'b1);
      pulse_start(0, 32'h1122_3344);
      ok = 1'b0;
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         if (ifs[0].frame_done) begin
            ok = 1'b1;
            break;
         end
      end
      check("fdrop_frame_done_seen", ok, 1'b1);
      sd[0] = 32'h5555_5555;
      ss[0] = 1'b1;
      @(negedge clk);
      ss[0] = 1'b0;
      repeat (40) @(negedge clk);
      compare_bytes("fdrop", 0, base, fd0);
      check("fdrop_still_idle", ifs[0].sending, 1'b0);

      // busy stall at frame start
      base = cap[0].size();
      fd0  = fd_cnt[0];
      build_text("07:08:09.10", 1'b1);
      force_busy = 1'b1;
      pulse_start(0, 32'h0708_0910);
      seen = 0;
      repeat (18) begin
         @(negedge clk);
         if (ifs[0].tx_start) seen++;
      end
      check("stall_no_start", seen, 0);
      force_busy = 1'b0;
      @(negedge clk);
      check("stall_first_start", ifs[0].tx_start, 1'b1);
      check_frame("stall", 0, base, fd0);

      // asynchronous reset mid-frame, then a fresh frame
      base = cap[0].size();
      fd0  = fd_cnt[0];
      pulse_start(0, 32'h1111_2222);
      wait_bytes(0, base + 5, 400, ok);
      check("rst_reach_byte5", ok, 1'b1);
      #1 rst = 1'b1;
      #1;
      check("rst_mid_tx_start", ifs[0].tx_start, 1'b0);
      check("rst_mid_tx_data", ifs[0].tx_data, 8'h00);
      check("rst_mid_sending", ifs[0].sending, 1'b0);
      check("rst_mid_frame_done", ifs[0].frame_done, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      check("rst_no_more_bytes", cap[0].size() - base, 5);
      check("rst_no_frame_done", fd_cnt[0] - fd0, 0);
      base = cap[0].size();
      fd0  = fd_cnt[0];
      build_text("20:10:40.50", 1'b1);
      pulse_start(0, 32'h2010_4050);
      check_frame("after_reset", 0, base, fd0);

      // bare 11-byte frame
      base = cap[1].size();
      fd0  = fd_cnt[1];
      build_text("01:02:03.04", 1'b0);
      pulse_start(1, 32'h0102_0304);
      check_frame("nocrlf", 1, base, fd0);

      // randomized frames against the reference model
      for (int r = 0; r < 12; r++) begin
         int id;
         id = (r % 3 == 2) ? 1 : 0;
         rd = $urandom();
         base = cap[id].size();
         fd0  = fd_cnt[id];
         build_model(rd, id == 0);
         pulse_start(id, rd);
         check_frame($sformatf("rand%0d_%08h", r, rd), id, base, fd0);
      end

      for (int id = 0; id < 2; id++) begin
         check($sformatf("dut%0d_start_while_busy", id), viol[id], 0);
         check($sformatf("dut%0d_done_to_start_gap", id), gap_err[id], 0);
         check($sformatf("dut%0d_tx_data_stable", id), stab_err[id], 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
